ransac_inlier_scorer: RTL
=========================

// Module: ransac_inlier_scorer
// PURPOSE
//  Consumes the per-point distance stream from fast_point_distance_to_plane and scores candidate planes.
//  Counts inliers (distance < threshold) per plane, keeps the plane with the highest count over a
//  RANSAC run of `iterations` planes, then presents the winner with a valid/ready handshake.
//  Sits directly downstream of the distance stage; the candidate plane arrives via its pipeline side-band.
// PARAMETERS
//  count_bits  default 16  width of inlier counters (per-plane and best); saturating
//  iter_bits   default 12  width of the iteration (plane) counter and the iterations input
// PORTS
//  clock          in   1                 rising-edge clock
//  reset_n        in   1                 asynchronous, active-low reset
//  start          in   1                 pulse: begin a run (honoured only in IDLE)
//  threshold      in   fixed_t           inlier bound, sampled at start
//  iterations     in   iter_bits         planes in this run, sampled at start
//  in_valid       in   1                 distance beat valid (no backpressure; upstream is 1 result/cycle)
//  in_last        in   1                 beat is the final point of the current plane
//  in_distance    in   fixed_t           |point-to-plane| distance from upstream
//  in_plane       in   plane_t           plane the beat belongs to (pipeline side-band)
//  busy           out  1                 high in SCORING
//  plane_score_valid out 1               1-cycle pulse per completed plane
//  plane_score    out  count_bits        inlier count of that plane
//  best_plane     out  plane_t           current best plane
//  best_count     out  count_bits        inlier count of best_plane
//  best_found     out  1                 at least one plane scored this run
//  result_valid   in/out: out 1          final result available (DONE)
//  result_ready   in   1                 consumer accepts result
//  overrun        out  1                 sticky: in_valid seen outside SCORING; cleared by start
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; all outputs 0 (best_plane all-zero fields); counters 0.
//  States: IDLE -> SCORING on start (iterations!=0); IDLE -> DONE on start with iterations==0.
//   SCORING -> DONE on the in_last beat of plane index iterations-1. DONE -> IDLE on result_valid&result_ready.
//  start: latches threshold/iterations; clears cur_count, plane_idx, best_count, best_found, overrun,
//   best_plane. start outside IDLE ignored.
//  Inlier test: in_distance < threshold (strict, signed). in_distance with sign bit set (abs overflow
//   of most-negative value) is NOT an inlier.
//  Per beat in SCORING with in_valid: inc = inlier; sum = cur_count + inc, saturated at 2^count_bits-1.
//   !in_last: cur_count <= sum.
//   in_last: plane_score <= sum, plane_score_valid pulses next cycle; cur_count <= 0; plane_idx++.
//    Replace best when !best_found or sum > best_count (strict: ties keep earlier plane):
//    best_plane <= in_plane, best_count <= sum, best_found <= 1. All updates visible 1 cycle after beat.
//  Plane with zero beats before in_last is impossible; in_last beat itself is always scored.
//  result_valid asserts the cycle after the final in_last beat (or after start when iterations==0,
//   with best_found=0) and holds, with best_* stable, until result_ready; released cycle after handshake.
//  result_ready outside DONE ignored. in_valid in IDLE/DONE: beat dropped, overrun <= 1.
//  Back-to-back planes: in_last on consecutive cycles is legal; each scored independently.
//  Reset mid-run: immediate return to IDLE, partial results discarded.
// TESTING
//  iterations=1, threshold=1.0, distances {0.5,2.0,0.9,1.0(last)} -> plane_score=2, best_count=2, result_valid next cycle.
//  iterations=3, scores 3,5,5 (planes A,B,C) -> best_plane=B, best_count=5 (tie keeps B).
//  count_bits=4, 20 inlier beats then last -> plane_score=15 (saturated).
//  in_distance=0x8000.. (negative) with threshold=max -> not counted; plane_score=0, best_found=1.
//  iterations=0, start -> result_valid after 1 cycle, best_found=0; hold result_ready=0 5 cycles -> outputs stable.
//  reset_n low mid-plane 2 of 3 -> all outputs 0 asynchronously; in_valid in IDLE -> overrun=1, cleared by next start.

Source files
------------

// File: rtl/ransac_inlier_scorer.sv
// ---------------------------------------------------------------------------
// ransac_pkg / ransac_inlier_scorer
//
// Purpose:
//   Scores candidate RANSAC planes from the per-point distance stream produced
//   by the point-to-plane distance stage. For each plane, the block counts the
//   points whose distance is strictly below the run threshold. Over a run of
//   `iterations` planes it keeps the plane with the highest inlier count. When
//   the run ends it presents the winning plane through a valid/ready handshake.
//
// Fixed-point format:
//   fixed_t is signed Q8.8, so 1.0 is encoded as 16'h0100.
//   plane_t carries four fixed_t fields: normal x/y/z and offset d.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   start                 pulse that begins a run; honoured only in IDLE
//   threshold             inlier bound, latched at start
//   iterations            number of planes in the run, latched at start
//   in_valid / in_last    distance beat valid / final point of the current plane
//   in_distance           |point-to-plane| distance
//   in_plane              plane that the beat belongs to (side-band)
//   busy                  high while scoring
//   plane_score_valid     1-cycle pulse for each completed plane
//   plane_score           inlier count of the plane that just completed
//   best_plane            best plane found so far in this run
//   best_count            inlier count of best_plane
//   best_found            at least one plane has been scored in this run
//   result_valid          final result held until result_ready
//   result_ready          consumer accepts the result
//   overrun               sticky flag: a beat arrived outside scoring
// ---------------------------------------------------------------------------
package ransac_pkg;
   localparam int FixedBits = 16;

   typedef logic signed [FixedBits-1:0] fixed_t;

   typedef struct packed {
      fixed_t nx;
      fixed_t ny;
      fixed_t nz;
      fixed_t d;
   } plane_t;
endpackage

module ransac_inlier_scorer
   import ransac_pkg::*;
#(
   parameter int count_bits = 16,
   parameter int iter_bits  = 12
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  fixed_t                threshold,
   input  logic [iter_bits-1:0]  iterations,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  fixed_t                in_distance,
   input  plane_t                in_plane,
   output logic                  busy,
   output logic                  plane_score_valid,
   output logic [count_bits-1:0] plane_score,
   output plane_t                best_plane,
   output logic [count_bits-1:0] best_count,
   output logic                  best_found,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      StIdle,
      StScoring,
      StDone
   } state_t;

   state_t                r_state;
   fixed_t                r_threshold;
   logic [iter_bits-1:0]  r_iterations;
   logic [iter_bits-1:0]  r_planeIdx;
   logic [count_bits-1:0] r_curCount;
   logic [count_bits-1:0] r_planeScore;
   logic                  r_planeScoreValid;
   plane_t                r_bestPlane;
   logic [count_bits-1:0] r_bestCount;
   logic                  r_bestFound;
   logic                  r_resultValid;
   logic                  r_overrun;

   logic                  w_isInlier;
   logic [count_bits:0]   w_sumWide;
   logic [count_bits-1:0] w_sum;
   logic                  w_isLastPlane;
   logic                  w_takeBest;

   // Inlier test. A distance with its sign bit set comes from an abs()
   // overflow of the most-negative value upstream, so it is never an inlier
   // even when the threshold is the largest positive value.
   assign w_isInlier = ~in_distance[FixedBits-1] & (in_distance < r_threshold);

   // Running count including this beat. The sum is one bit wider so that the
   // carry detects saturation at the all-ones value.
   assign w_sumWide = {1'b0, r_curCount} + {{count_bits{1'b0}}, w_isInlier};
   assign w_sum     = w_sumWide[count_bits] ? {count_bits{1'b1}} : w_sumWide[count_bits-1:0];

   // The final plane of the run is index iterations-1. A run of zero
   // iterations never reaches the scoring state.
   assign w_isLastPlane = (r_planeIdx == (r_iterations - iter_bits'(1)));

   // The comparison is strict, so a tie keeps the plane that was seen first.
   assign w_takeBest = ~r_bestFound | (w_sum > r_bestCount);

   // Control FSM and all datapath state. Every output comes straight from a
   // register, so the consumer sees glitch-free values. The plane-score pulse
   // defaults low and is raised only on the cycle after an in_last beat.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state           <= StIdle;
         r_threshold       <= '0;
         r_iterations      <= '0;
         r_planeIdx        <= '0;
         r_curCount        <= '0;
         r_planeScore      <= '0;
         r_planeScoreValid <= 1'b0;
         r_bestPlane       <= '0;
         r_bestCount       <= '0;
         r_bestFound       <= 1'b0;
         r_resultValid     <= 1'b0;
         r_overrun         <= 1'b0;
      end else begin
         r_planeScoreValid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_threshold  <= threshold;
                  r_iterations <= iterations;
                  r_planeIdx   <= '0;
                  r_curCount   <= '0;
                  r_bestPlane  <= '0;
                  r_bestCount  <= '0;
                  r_bestFound  <= 1'b0;
                  r_overrun    <= 1'b0;
                  if (iterations == '0) begin
                     r_resultValid <= 1'b1;
                     r_state       <= StDone;
                  end else begin
                     r_state <= StScoring;
                  end
               end else if (in_valid) begin
                  r_overrun <= 1'b1;
               end
            end

            StScoring: begin
               if (in_valid) begin
                  if (in_last) begin
                     r_planeScore      <= w_sum;
                     r_planeScoreValid <= 1'b1;
                     r_curCount        <= '0;
                     r_planeIdx        <= r_planeIdx + iter_bits'(1);
                     if (w_takeBest) begin
                        r_bestPlane <= in_plane;
                        r_bestCount <= w_sum;
                        r_bestFound <= 1'b1;
                     end
                     if (w_isLastPlane) begin
                        r_resultValid <= 1'b1;
                        r_state       <= StDone;
                     end
                  end else begin
                     r_curCount <= w_sum;
                  end
               end
            end

            StDone: begin
               if (in_valid) begin
                  r_overrun <= 1'b1;
               end
               if (result_ready) begin
                  r_resultValid <= 1'b0;
                  r_state       <= StIdle;
               end
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign busy              = (r_state == StScoring);
   assign plane_score_valid = r_planeScoreValid;
   assign plane_score       = r_planeScore;
   assign best_plane        = r_bestPlane;
   assign best_count        = r_bestCount;
   assign best_found        = r_bestFound;
   assign result_valid      = r_resultValid;
   assign overrun           = r_overrun;

endmodule
